// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IDLE/RUN/HALTED fetch FSM with a one-entry registered output and redirect/halt control.
// Optional performance counters (fetch_count, stall_count) are enabled with FETCH_PERF_COUNTERS_EN.
module instruction_fetch_unit #(
  parameter int INSTRUCTION_MEMORY_ADDRESS_WIDTH = 16,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] RESET_PC = 16'h0000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic halt_req,
  input  logic redirect_valid,
  input  logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] redirect_address,
  output logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] instruction_address,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_data,
  output logic fetch_valid,
  input  logic fetch_ready,
  output logic [INSTRUCTION_WIDTH-1:0] fetch_instruction,
  output logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] fetch_pc,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic busy,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`else
  output logic busy
`endif
);
  localparam int AW = INSTRUCTION_MEMORY_ADDRESS_WIDTH;
  localparam int IW = INSTRUCTION_WIDTH;
  localparam logic [AW-1:0] PC_ONE = 1;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, fpc_q, fpc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic valid_q, valid_d;
  logic slot_free, capture;
  assign slot_free = !valid_q || fetch_ready;
  assign capture = !redirect_valid && state_q == RUN && !halt_req && slot_free;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      fpc_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      fpc_q <= fpc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end
  // Redirect flushes the output and wins over everything but reset; halt keeps an unaccepted output.
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    fpc_d = fpc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect_valid) begin
      pc_d = redirect_address;
      valid_d = 1'b0;
      state_d = (state_q == RUN && halt_req) ? HALTED : state_q;
    end else if (capture) begin
      instr_d = instruction_data;
      fpc_d = pc_q;
      valid_d = 1'b1;
      pc_d = pc_q + PC_ONE;
    end else if (state_q == RUN) begin
      state_d = halt_req ? HALTED : RUN;
      valid_d = valid_q && !(halt_req && fetch_ready);
    end else begin
      valid_d = valid_q && !fetch_ready;
      state_d = (start && !halt_req) ? RUN : state_q;
    end
  end
  assign instruction_address = pc_q;
  assign fetch_valid = valid_q;
  assign fetch_instruction = instr_q;
  assign fetch_pc = fpc_q;
  assign busy = state_q == RUN;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fcnt_q, scnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + {31'd0, capture};
      scnt_q <= scnt_q + {31'd0, state_q == RUN && valid_q && !fetch_ready};
    end
  end
  assign fetch_count = fcnt_q;
  assign stall_count = scnt_q;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenario tasks for instruction_fetch_unit, with a second instance at RESET_PC=16'hFFFF.
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic rst, start, halt_req, redirect_valid, fetch_ready;
  logic [15:0] redirect_address, addr1, addr2, fpc1, fpc2;
  logic [31:0] data1, data2, fi1, fi2;
  logic fv1, fv2, busy1, busy2;
  int n_cmp = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    case (a)
      16'd0: mem_rd = 32'h02103083;
      16'd1: mem_rd = 32'hAFBFCFDF;
      16'd2: mem_rd = 32'h7034EF55;
      16'd3: mem_rd = 32'h11223344;
      default: mem_rd = 32'hDEADBEEF;
    endcase
  endfunction
  assign data1 = mem_rd(addr1);
  assign data2 = mem_rd(addr2);
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fc1, sc1, fc2, sc2;
`endif
  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_address(redirect_address),
    .instruction_address(addr1), .instruction_data(data1),
    .fetch_valid(fv1), .fetch_ready(fetch_ready),
    .fetch_instruction(fi1), .fetch_pc(fpc1),
`ifdef FETCH_PERF_COUNTERS_EN
    .busy(busy1), .fetch_count(fc1), .stall_count(sc1)
`else
    .busy(busy1)
`endif
  );
  instruction_fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_address(redirect_address),
    .instruction_address(addr2), .instruction_data(data2),
    .fetch_valid(fv2), .fetch_ready(fetch_ready),
    .fetch_instruction(fi2), .fetch_pc(fpc2),
`ifdef FETCH_PERF_COUNTERS_EN
    .busy(busy2), .fetch_count(fc2), .stall_count(sc2)
`else
    .busy(busy2)
`endif
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_address = 16'h0000; fetch_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++; if (fv1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", fv1); end
    n_cmp++; if (fi1 !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h want=00000000", fi1); end
    n_cmp++; if (fpc1 !== 16'h0) begin n_fail++; $display("FAIL reset_pc_out got=%h want=0000", fpc1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy1); end
    n_cmp++; if (addr1 !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got=%h want=0000", addr1); end
    n_cmp++; if (addr2 !== 16'hFFFF) begin n_fail++; $display("FAIL reset_addr_wrapdut got=%h want=FFFF", addr2); end
  endtask
  task automatic test_stream();
    logic [31:0] exp_i [5] = '{32'h02103083, 32'hAFBFCFDF, 32'h7034EF55, 32'h11223344, 32'hDEADBEEF};
    do_reset();
    pulse_start();
    n_cmp++; if (busy1 !== 1'b1 || fv1 !== 1'b0) begin n_fail++; $display("FAIL start_state busy=%b valid=%b want busy=1 valid=0", busy1, fv1); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (fv1 !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got=%b want=1", i, fv1); end
      n_cmp++; if (fi1 !== exp_i[i]) begin n_fail++; $display("FAIL stream_instr[%0d] got=%h want=%h", i, fi1, exp_i[i]); end
      n_cmp++; if (fpc1 !== 16'(i)) begin n_fail++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, fpc1, 16'(i)); end
    end
`ifdef FETCH_PERF_COUNTERS_EN
    n_cmp++; if (fc1 !== 32'd5) begin n_fail++; $display("FAIL stream_fetch_count got=%0d want=5", fc1); end
`endif
  endtask
  task automatic test_stall();
    do_reset();
    pulse_start();
    step();
    step();
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (fv1 !== 1'b1 || fi1 !== 32'hAFBFCFDF || fpc1 !== 16'd1) begin n_fail++; $display("FAIL stall_hold[%0d] got=%b/%h/%h want=1/AFBFCFDF/0001", i, fv1, fi1, fpc1); end
      n_cmp++; if (addr1 !== 16'd2) begin n_fail++; $display("FAIL stall_addr[%0d] got=%h want=0002", i, addr1); end
    end
    fetch_ready = 1'b1;
    step();
    n_cmp++; if (fv1 !== 1'b1 || fi1 !== 32'h7034EF55 || fpc1 !== 16'd2) begin n_fail++; $display("FAIL stall_release got=%b/%h/%h want=1/7034EF55/0002", fv1, fi1, fpc1); end
`ifdef FETCH_PERF_COUNTERS_EN
    n_cmp++; if (sc1 !== 32'd3) begin n_fail++; $display("FAIL stall_count got=%0d want=3", sc1); end
    n_cmp++; if (fc1 !== 32'd3) begin n_fail++; $display("FAIL stall_fetch_count got=%0d want=3", fc1); end
`endif
  endtask
  task automatic test_redirect();
    do_reset();
    pulse_start();
    step();
    redirect_valid = 1'b1; redirect_address = 16'h0003;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (fv1 !== 1'b0 || addr1 !== 16'h0003 || busy1 !== 1'b1) begin n_fail++; $display("FAIL redirect_flush got valid=%b addr=%h busy=%b want 0/0003/1", fv1, addr1, busy1); end
    step();
    n_cmp++; if (fv1 !== 1'b1 || fi1 !== 32'h11223344 || fpc1 !== 16'h0003) begin n_fail++; $display("FAIL redirect_target got=%b/%h/%h want=1/11223344/0003", fv1, fi1, fpc1); end
  endtask
  task automatic test_wrap();
    do_reset();
    pulse_start();
    step();
    n_cmp++; if (fv2 !== 1'b1 || fi2 !== 32'hDEADBEEF || fpc2 !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_first got=%b/%h/%h want=1/DEADBEEF/FFFF", fv2, fi2, fpc2); end
    step();
    n_cmp++; if (fv2 !== 1'b1 || fi2 !== 32'h02103083 || fpc2 !== 16'h0000) begin n_fail++; $display("FAIL wrap_second got=%b/%h/%h want=1/02103083/0000", fv2, fi2, fpc2); end
  endtask
  task automatic test_halt();
    do_reset();
    pulse_start();
    step();
    fetch_ready = 1'b0; halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL halt_busy got=%b want=0", busy1); end
    n_cmp++; if (fv1 !== 1'b1 || fi1 !== 32'h02103083 || fpc1 !== 16'h0000 || addr1 !== 16'h0001) begin n_fail++; $display("FAIL halt_hold got=%b/%h/%h addr=%h want=1/02103083/0000 addr=0001", fv1, fi1, fpc1, addr1); end
    step();
    n_cmp++; if (fv1 !== 1'b1 || fi1 !== 32'h02103083) begin n_fail++; $display("FAIL halt_hold2 got=%b/%h want=1/02103083", fv1, fi1); end
    fetch_ready = 1'b1;
    step();
    n_cmp++; if (fv1 !== 1'b0 || addr1 !== 16'h0001) begin n_fail++; $display("FAIL halt_accept got valid=%b addr=%h want 0/0001", fv1, addr1); end
    step();
    n_cmp++; if (fv1 !== 1'b0 || busy1 !== 1'b0) begin n_fail++; $display("FAIL halt_no_capture got valid=%b busy=%b want 0/0", fv1, busy1); end
    pulse_start();
    n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL halt_resume_busy got=%b want=1", busy1); end
    step();
    n_cmp++; if (fv1 !== 1'b1 || fi1 !== 32'hAFBFCFDF || fpc1 !== 16'h0001) begin n_fail++; $display("FAIL halt_resume got=%b/%h/%h want=1/AFBFCFDF/0001", fv1, fi1, fpc1); end
  endtask
  task automatic test_start_halt();
    do_reset();
    start = 1'b1; halt_req = 1'b1;
    step();
    start = 1'b0; halt_req = 1'b0;
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL start_halt_busy got=%b want=0", busy1); end
    step();
    n_cmp++; if (fv1 !== 1'b0 || addr1 !== 16'h0000) begin n_fail++; $display("FAIL start_halt_idle got valid=%b addr=%h want 0/0000", fv1, addr1); end
  endtask
  task automatic test_mid_reset();
    do_reset();
    pulse_start();
    step();
    step();
    step();
    rst = 1'b1; redirect_valid = 1'b1; redirect_address = 16'h0002;
    step();
    rst = 1'b0; redirect_valid = 1'b0;
    n_cmp++; if (fv1 !== 1'b0 || busy1 !== 1'b0 || addr1 !== 16'h0000) begin n_fail++; $display("FAIL mid_reset got valid=%b busy=%b addr=%h want 0/0/0000", fv1, busy1, addr1); end
    n_cmp++; if (fi1 !== 32'h0 || fpc1 !== 16'h0) begin n_fail++; $display("FAIL mid_reset_out got=%h/%h want=00000000/0000", fi1, fpc1); end
`ifdef FETCH_PERF_COUNTERS_EN
    n_cmp++; if (fc1 !== 32'd0 || sc1 !== 32'd0) begin n_fail++; $display("FAIL mid_reset_counters got=%0d/%0d want=0/0", fc1, sc1); end
`endif
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_start_halt();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
